// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} between IF and the IF/ID register, with redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  input  logic [XLEN-1:0]  enq_pc_i,
  input  logic [31:0]      enq_instr_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic [XLEN-1:0]  deq_pc_o,
  output logic [31:0]      deq_instr_o,
  input  logic             deq_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             almost_full_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic          empty, full, enq_fire, deq_fire;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_idx = wp_q[IW-1:0];
  assign rd_idx = rp_q[IW-1:0];

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wp_q == rp_q);
  assign full  = (wr_idx == rd_idx) && (wp_q[PW-1] != rp_q[PW-1]);

  assign enq_ready_o   = !full && !flush_i;
  assign deq_valid_o   = !empty;
  assign enq_fire      = enq_valid_i && enq_ready_o;
  assign deq_fire      = deq_valid_o && deq_ready_i;
  assign count_o       = CNT_W'(wp_q - rp_q);
  assign almost_full_o = (count_o >= CNT_W'(DEPTH - 1));

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (enq_fire) wp_d = wp_q + PW'(1);
      if (deq_fire) rp_d = rp_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage is intentionally not reset; only the pointers define occupancy.
  if (XLEN == 32) begin : g_pkt
    fetch_pkt_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (enq_fire) mem_q[wr_idx] <= '{pc: enq_pc_i, instr: enq_instr_i};
    end

    assign deq_pc_o    = mem_q[rd_idx].pc;
    assign deq_instr_o = mem_q[rd_idx].instr;
  end else begin : g_split
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];

    always_ff @(posedge clk) begin
      if (enq_fire) begin
        pc_q[wr_idx]    <= enq_pc_i;
        instr_q[wr_idx] <= enq_instr_i;
      end
    end

    assign deq_pc_o    = pc_q[rd_idx];
    assign deq_instr_o = instr_q[rd_idx];
  end

endmodule
